// File: rtl/fg_prog_sequencer.sv
// Floating-gate programming sequencer for one CAB island: addresses a single switch,
// applies a counted train of injection/tunnelling pulses, then returns the island to run mode.
module fg_prog_sequencer #(
    parameter int ROW_BITS   = 6,
    parameter int COL_BITS   = 5,
    parameter int NUM_DRAIN  = 12,
    parameter int PW_BITS    = 16,
    parameter int NP_BITS    = 8,
    parameter int SETTLE_CYC = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [ROW_BITS-1:0]  cmd_row,
    input  logic [COL_BITS-1:0]  cmd_col,
    input  logic [1:0]           cmd_mode,
    input  logic [PW_BITS-1:0]   cmd_pw,
    input  logic [PW_BITS-1:0]   cmd_gap,
    input  logic [NP_BITS-1:0]   cmd_np,
    input  logic                 abort,
    output logic [ROW_BITS-1:0]  dec_row,
    output logic [COL_BITS-1:0]  dec_col,
    output logic                 dec_en,
    output logic [NUM_DRAIN-1:0] drain_sel,
    output logic                 prog,
    output logic                 run,
    output logic                 vinj_pulse,
    output logic                 vtun_pulse,
    output logic                 busy,
    output logic                 done,
    output logic [1:0]           err
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CHECK   = 3'd1,
        S_SETTLE  = 3'd2,
        S_PULSE   = 3'd3,
        S_GAP     = 3'd4,
        S_RECOVER = 3'd5,
        S_DONE    = 3'd6
    } state_t;

    localparam logic [1:0] MODE_INJECT = 2'd0;
    localparam logic [1:0] MODE_TUNNEL = 2'd1;
    localparam logic [1:0] MODE_READ   = 2'd2;
    localparam logic [1:0] MODE_RSVD   = 2'd3;

    localparam logic [1:0] ERR_OK    = 2'd0;
    localparam logic [1:0] ERR_ROW   = 2'd1;
    localparam logic [1:0] ERR_MODE  = 2'd2;
    localparam logic [1:0] ERR_ABORT = 2'd3;

    state_t               state_q, state_d;
    logic                 rdy_q;
    logic [PW_BITS-1:0]   cnt_q, cnt_d;
    logic [NP_BITS-1:0]   pcnt_q, pcnt_d;
    logic [1:0]           err_q, err_d;
    logic                 abort_pend_q, abort_pend_d;

    logic [ROW_BITS-1:0]  row_q;
    logic [COL_BITS-1:0]  col_q;
    logic [1:0]           mode_q;
    logic [PW_BITS-1:0]   pw_q;
    logic [PW_BITS-1:0]   gap_q;
    logic [NP_BITS-1:0]   np_q;

    logic                 accept;
    logic                 bad_row;
    logic                 skip_pulses;
    logic                 abort_eff;
    logic [PW_BITS-1:0]   pw_m1;
    logic [PW_BITS-1:0]   gap_m1;
    logic                 settle_last;
    logic                 pw_last;
    logic                 gap_last;
    logic                 train_last;
    logic                 in_prog;

    assign accept      = cmd_valid & cmd_ready;
    assign bad_row     = 32'(row_q) >= NUM_DRAIN;
    assign skip_pulses = (mode_q == MODE_READ) || (np_q == '0);
    assign abort_eff   = abort | abort_pend_q;

    // Zero width/gap behave as one cycle; subtracting first keeps the all-ones width exact.
    assign pw_m1       = (pw_q  == '0) ? '0 : pw_q  - PW_BITS'(1);
    assign gap_m1      = (gap_q == '0) ? '0 : gap_q - PW_BITS'(1);
    assign settle_last = cnt_q == PW_BITS'(SETTLE_CYC - 1);
    assign pw_last     = cnt_q == pw_m1;
    assign gap_last    = cnt_q == gap_m1;
    assign train_last  = pcnt_q == (np_q - NP_BITS'(1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) state_d = S_CHECK;
            end
            S_CHECK: begin
                if (bad_row || (mode_q == MODE_RSVD)) state_d = S_DONE;
                else                                   state_d = S_SETTLE;
            end
            S_SETTLE: begin
                if (abort_eff)        state_d = S_RECOVER;
                else if (settle_last) state_d = skip_pulses ? S_RECOVER : S_PULSE;
            end
            S_PULSE: begin
                if (abort_eff)    state_d = S_RECOVER;
                else if (pw_last) state_d = train_last ? S_RECOVER : S_GAP;
            end
            S_GAP: begin
                if (abort_eff)     state_d = S_RECOVER;
                else if (gap_last) state_d = S_PULSE;
            end
            S_RECOVER: begin
                if (settle_last) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_d        = (state_d == state_q) ? cnt_q + PW_BITS'(1) : '0;
        pcnt_d       = pcnt_q;
        err_d        = err_q;
        abort_pend_d = abort_pend_q;
        if (accept) begin
            pcnt_d       = '0;
            err_d        = ERR_OK;
            abort_pend_d = 1'b0;
        end
        case (state_q)
            S_CHECK: begin
                if (bad_row)                    err_d = ERR_ROW;
                else if (mode_q == MODE_RSVD)   err_d = ERR_MODE;
                else if (abort)                 abort_pend_d = 1'b1;
            end
            S_SETTLE, S_GAP: begin
                if (abort_eff) err_d = ERR_ABORT;
            end
            S_PULSE: begin
                if (abort_eff)    err_d = ERR_ABORT;
                else if (pw_last) pcnt_d = pcnt_q + NP_BITS'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdy_q        <= 1'b0;
            cnt_q        <= '0;
            pcnt_q       <= '0;
            err_q        <= ERR_OK;
            abort_pend_q <= 1'b0;
        end else begin
            rdy_q        <= 1'b1;
            cnt_q        <= cnt_d;
            pcnt_q       <= pcnt_d;
            err_q        <= err_d;
            abort_pend_q <= abort_pend_d;
        end
    end

    // Command fields are pure data: latched on accept only, masked at the outputs.
    always_ff @(posedge clk) begin
        if (accept) begin
            row_q  <= cmd_row;
            col_q  <= cmd_col;
            mode_q <= cmd_mode;
            pw_q   <= cmd_pw;
            gap_q  <= cmd_gap;
            np_q   <= cmd_np;
        end
    end

    assign in_prog = (state_q == S_SETTLE) || (state_q == S_PULSE) ||
                     (state_q == S_GAP)    || (state_q == S_RECOVER);

    always_comb begin
        cmd_ready  = (state_q == S_IDLE) && rdy_q;
        busy       = state_q != S_IDLE;
        dec_en     = in_prog;
        prog       = in_prog;
        run        = ~in_prog;
        dec_row    = in_prog ? row_q : '0;
        dec_col    = in_prog ? col_q : '0;
        drain_sel  = in_prog ? (NUM_DRAIN'(1) << row_q) : '0;
        vinj_pulse = (state_q == S_PULSE) && (mode_q == MODE_INJECT);
        vtun_pulse = (state_q == S_PULSE) && (mode_q == MODE_TUNNEL);
        done       = state_q == S_DONE;
        err        = (state_q == S_DONE) ? err_q : ERR_OK;
    end

endmodule

// File: tb/tb_fg_prog_sequencer.sv
// Directed bench for fg_prog_sequencer: per-command cycle statistics against hand-derived timing.
module tb_fg_prog_sequencer;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [5:0]  cmd_row;
    logic [4:0]  cmd_col;
    logic [1:0]  cmd_mode;
    logic [15:0] cmd_pw;
    logic [15:0] cmd_gap;
    logic [7:0]  cmd_np;
    logic        abort;
    logic [5:0]  dec_row;
    logic [4:0]  dec_col;
    logic        dec_en;
    logic [11:0] drain_sel;
    logic        prog;
    logic        run;
    logic        vinj_pulse;
    logic        vtun_pulse;
    logic        busy;
    logic        done;
    logic [1:0]  err;

    fg_prog_sequencer #(
        .ROW_BITS(6), .COL_BITS(5), .NUM_DRAIN(12),
        .PW_BITS(16), .NP_BITS(8), .SETTLE_CYC(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_row(cmd_row), .cmd_col(cmd_col), .cmd_mode(cmd_mode), .cmd_pw(cmd_pw),
        .cmd_gap(cmd_gap), .cmd_np(cmd_np), .abort(abort), .dec_row(dec_row),
        .dec_col(dec_col), .dec_en(dec_en), .drain_sel(drain_sel), .prog(prog),
        .run(run), .vinj_pulse(vinj_pulse), .vtun_pulse(vtun_pulse), .busy(busy),
        .done(done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int failures;

    int s_en, s_prog, s_vinj, s_vtun, s_rises, s_maxrun, s_first, s_last;
    int s_done_k, s_viol, s_rdy_busy, s_run_len;
    logic [11:0] s_drain;
    logic [5:0]  s_row;
    logic [4:0]  s_col;
    logic [1:0]  s_err;
    logic        s_prev;
    logic [32:0] obs;

    localparam logic [32:0] RST_EXP = {6'd0, 5'd0, 1'b0, 12'd0, 1'b0, 1'b1,
                                       1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0};

    // Starts on a negedge with the sequencer idle; returns on the negedge showing done.
    task automatic run_cmd(input logic [5:0] row, input logic [4:0] col, input logic [1:0] mode,
                           input logic [15:0] pw, input logic [15:0] gap, input logic [7:0] np,
                           input int abort_k, input int abort_pulse, input bit hold_valid);
        logic pulse;
        s_en = 0; s_prog = 0; s_vinj = 0; s_vtun = 0; s_rises = 0; s_maxrun = 0;
        s_first = 0; s_last = 0; s_done_k = 0; s_viol = 0; s_rdy_busy = 0; s_run_len = 0;
        s_drain = '0; s_row = '0; s_col = '0; s_err = 2'd0; s_prev = 1'b0;
        cmd_valid = 1'b1; cmd_row = row; cmd_col = col; cmd_mode = mode;
        cmd_pw = pw; cmd_gap = gap; cmd_np = np;
        abort = (abort_k == -1);
        @(posedge clk);
        @(negedge clk);
        if (hold_valid) begin
            cmd_row = ~row; cmd_col = ~col; cmd_mode = 2'd0; cmd_np = 8'd7;
        end else begin
            cmd_valid = 1'b0;
        end
        for (int k = 1; k <= 3000; k++) begin
            abort = 1'b0;
            pulse = vinj_pulse | vtun_pulse;
            if (dec_en) begin
                s_en++;
                if (s_en == 1) begin
                    s_drain = drain_sel; s_row = dec_row; s_col = dec_col;
                end else if (drain_sel !== s_drain || dec_row !== s_row || dec_col !== s_col) begin
                    s_viol++;
                end
            end
            if (prog) s_prog++;
            if (vinj_pulse) s_vinj++;
            if (vtun_pulse) s_vtun++;
            if (pulse && !s_prev) begin
                s_rises++;
                if (s_first == 0) s_first = k;
            end
            if (pulse) begin
                s_run_len++; s_last = k;
                if (s_run_len > s_maxrun) s_maxrun = s_run_len;
            end else begin
                s_run_len = 0;
            end
            if ((vinj_pulse && vtun_pulse) || (pulse && (!prog || !dec_en)) ||
                (run !== ~prog) || (dec_en !== prog) || !busy) s_viol++;
            if (cmd_ready) s_rdy_busy++;
            if (pulse && !s_prev && abort_pulse > 0 && s_rises == abort_pulse) abort = 1'b1;
            if (k == abort_k) abort = 1'b1;
            s_prev = pulse;
            if (done) begin
                s_done_k = k; s_err = err;
                break;
            end
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        abort = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cmd_valid = 1'b0; abort = 1'b0;
        cmd_row = '0; cmd_col = '0; cmd_mode = '0; cmd_pw = '0; cmd_gap = '0; cmd_np = '0;
        repeat (3) @(negedge clk);
        obs = {dec_row, dec_col, dec_en, drain_sel, prog, run, vinj_pulse, vtun_pulse,
               busy, done, err, cmd_ready};
        checks++; if (obs !== RST_EXP) begin failures++; $display("FAIL reset_outputs got=%h exp=%h", obs, RST_EXP); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_ready_rise got=%b exp=1", cmd_ready); end
    endtask

    task automatic test_inject();
        run_cmd(6'd3, 5'd7, 2'd0, 16'd5, 16'd2, 8'd3, 0, 0, 1'b0);
        checks++; if (s_done_k != 29) begin failures++; $display("FAIL inj_done_cycle got=%0d exp=29", s_done_k); end
        checks++; if (s_err !== 2'd0) begin failures++; $display("FAIL inj_err got=%0d exp=0", s_err); end
        checks++; if (s_en != 27) begin failures++; $display("FAIL inj_dec_en_cycles got=%0d exp=27", s_en); end
        checks++; if (s_drain !== 12'h008 || s_row !== 6'd3 || s_col !== 5'd7) begin failures++; $display("FAIL inj_address got=%h/%0d/%0d exp=008/3/7", s_drain, s_row, s_col); end
        checks++; if (s_vinj != 15 || s_vtun != 0) begin failures++; $display("FAIL inj_pulse_cycles got=%0d/%0d exp=15/0", s_vinj, s_vtun); end
        checks++; if (s_rises != 3 || s_maxrun != 5) begin failures++; $display("FAIL inj_pulse_shape got=%0d/%0d exp=3/5", s_rises, s_maxrun); end
        checks++; if (s_first != 6 || s_last != 24) begin failures++; $display("FAIL inj_pulse_span got=%0d..%0d exp=6..24", s_first, s_last); end
        checks++; if (s_viol != 0 || s_rdy_busy != 0) begin failures++; $display("FAIL inj_invariants got=%0d/%0d exp=0/0", s_viol, s_rdy_busy); end
        @(negedge clk);
        checks++; if (cmd_ready !== 1'b1 || done !== 1'b0 || run !== 1'b1) begin failures++; $display("FAIL inj_post_done got=%b%b%b exp=101", cmd_ready, done, run); end
    endtask

    task automatic test_tunnel_pw0();
        run_cmd(6'd5, 5'd1, 2'd1, 16'd0, 16'd0, 8'd1, 0, 0, 1'b0);
        checks++; if (s_vtun != 1 || s_vinj != 0 || s_rises != 1) begin failures++; $display("FAIL tun_pulse got=%0d/%0d/%0d exp=1/0/1", s_vtun, s_vinj, s_rises); end
        checks++; if (s_en != 9 || s_done_k != 11 || s_err !== 2'd0) begin failures++; $display("FAIL tun_timing got=%0d/%0d/%0d exp=9/11/0", s_en, s_done_k, s_err); end
        checks++; if (s_drain !== 12'h020 || s_viol != 0) begin failures++; $display("FAIL tun_drain got=%h/%0d exp=020/0", s_drain, s_viol); end
        @(negedge clk);
    endtask

    task automatic test_read_holdoff();
        run_cmd(6'd11, 5'd31, 2'd2, 16'd3, 16'd3, 8'd10, 0, 0, 1'b1);
        checks++; if (s_prog != 8 || s_vinj != 0 || s_vtun != 0) begin failures++; $display("FAIL read_prog got=%0d/%0d/%0d exp=8/0/0", s_prog, s_vinj, s_vtun); end
        checks++; if (s_done_k != 10 || s_err !== 2'd0) begin failures++; $display("FAIL read_done got=%0d/%0d exp=10/0", s_done_k, s_err); end
        checks++; if (s_drain !== 12'h800 || s_row !== 6'd11 || s_col !== 5'd31) begin failures++; $display("FAIL read_address got=%h/%0d/%0d exp=800/11/31", s_drain, s_row, s_col); end
        checks++; if (s_viol != 0 || s_rdy_busy != 0) begin failures++; $display("FAIL read_holdoff got=%0d/%0d exp=0/0", s_viol, s_rdy_busy); end
        @(negedge clk);
    endtask

    task automatic test_np0_abort_on_accept();
        run_cmd(6'd0, 5'd4, 2'd0, 16'd9, 16'd9, 8'd0, -1, 0, 1'b0);
        checks++; if (s_en != 8 || s_vinj != 0 || s_done_k != 10) begin failures++; $display("FAIL np0_timing got=%0d/%0d/%0d exp=8/0/10", s_en, s_vinj, s_done_k); end
        checks++; if (s_err !== 2'd0 || s_drain !== 12'h001) begin failures++; $display("FAIL np0_status got=%0d/%h exp=0/001", s_err, s_drain); end
        @(negedge clk);
    endtask

    task automatic test_errors();
        run_cmd(6'd12, 5'd0, 2'd0, 16'd5, 16'd2, 8'd3, 0, 0, 1'b0);
        checks++; if (s_done_k != 2 || s_err !== 2'd1) begin failures++; $display("FAIL badrow_done got=%0d/%0d exp=2/1", s_done_k, s_err); end
        checks++; if (s_en != 0 || s_prog != 0) begin failures++; $display("FAIL badrow_idle got=%0d/%0d exp=0/0", s_en, s_prog); end
        @(negedge clk);
        run_cmd(6'd2, 5'd3, 2'd3, 16'd5, 16'd2, 8'd3, 0, 0, 1'b0);
        checks++; if (s_done_k != 2 || s_err !== 2'd2 || s_prog != 0) begin failures++; $display("FAIL badmode got=%0d/%0d/%0d exp=2/2/0", s_done_k, s_err, s_prog); end
        @(negedge clk);
    endtask

    task automatic test_abort();
        run_cmd(6'd4, 5'd2, 2'd0, 16'd5, 16'd2, 8'd5, 0, 2, 1'b0);
        checks++; if (s_rises != 2 || s_vinj != 6 || s_last != 13) begin failures++; $display("FAIL abort_pulse got=%0d/%0d/%0d exp=2/6/13", s_rises, s_vinj, s_last); end
        checks++; if (s_en != 16 || s_done_k != 18 || s_err !== 2'd3) begin failures++; $display("FAIL abort_recover got=%0d/%0d/%0d exp=16/18/3", s_en, s_done_k, s_err); end
        @(negedge clk);
        checks++; if (run !== 1'b1 || prog !== 1'b0) begin failures++; $display("FAIL abort_run_after got=%b%b exp=10", run, prog); end
        run_cmd(6'd1, 5'd1, 2'd0, 16'd5, 16'd2, 8'd3, 1, 0, 1'b0);
        checks++; if (s_en != 5 || s_vinj != 0 || s_done_k != 7 || s_err !== 2'd3) begin failures++; $display("FAIL abort_check got=%0d/%0d/%0d/%0d exp=5/0/7/3", s_en, s_vinj, s_done_k, s_err); end
        @(negedge clk);
        run_cmd(6'd3, 5'd7, 2'd0, 16'd5, 16'd2, 8'd3, 26, 0, 1'b0);
        checks++; if (s_done_k != 29 || s_err !== 2'd0 || s_en != 27) begin failures++; $display("FAIL abort_in_recover got=%0d/%0d/%0d exp=29/0/27", s_done_k, s_err, s_en); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int waited;
        cmd_valid = 1'b1; cmd_row = 6'd6; cmd_col = 5'd6; cmd_mode = 2'd0;
        cmd_pw = 16'd5; cmd_gap = 16'd2; cmd_np = 8'd3;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        waited = 0;
        while (!vinj_pulse && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        checks++; if (vinj_pulse !== 1'b1) begin failures++; $display("FAIL rst_reach_pulse got=%b exp=1", vinj_pulse); end
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        obs = {dec_row, dec_col, dec_en, drain_sel, prog, run, vinj_pulse, vtun_pulse,
               busy, done, err, cmd_ready};
        checks++; if (obs !== RST_EXP) begin failures++; $display("FAIL rst_mid_pulse got=%h exp=%h", obs, RST_EXP); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL rst_release_ready got=%b exp=1", cmd_ready); end
        run_cmd(6'd7, 5'd9, 2'd1, 16'd2, 16'd1, 8'd2, 0, 0, 1'b0);
        checks++; if (s_vtun != 4 || s_rises != 2 || s_en != 13 || s_done_k != 15 || s_err !== 2'd0) begin failures++; $display("FAIL b2b_first got=%0d/%0d/%0d/%0d/%0d exp=4/2/13/15/0", s_vtun, s_rises, s_en, s_done_k, s_err); end
        @(negedge clk);
        run_cmd(6'd8, 5'd0, 2'd0, 16'd1, 16'd3, 8'd2, 0, 0, 1'b0);
        checks++; if (s_vinj != 2 || s_en != 13 || s_drain !== 12'h100 || s_done_k != 15) begin failures++; $display("FAIL b2b_second got=%0d/%0d/%h/%0d exp=2/13/100/15", s_vinj, s_en, s_drain, s_done_k); end
        checks++; if (s_viol != 0) begin failures++; $display("FAIL b2b_invariants got=%0d exp=0", s_viol); end
        @(negedge clk);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_inject();
        test_tunnel_pw0();
        test_read_holdoff();
        test_np0_abort_on_accept();
        test_errors();
        test_abort();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
